// File: rtl/dest_pipe_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : pipe_pkg                                                        |
// | Purpose  : Shared types and constants for the destination-register         |
// |            pipeline tracker: entry layout, canonical bubble encoding and a  |
// |            stage-index width helper.                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int AW            = 5;  // register-address width
  localparam int DEPTH_DEFAULT = 3;  // EX/MEM, MEM/WB, WB/retire

  // One tracked instruction: is it present, does it write, and where.
  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] dest;
  } dest_entry_t;

  // Empty slots are always stored as all-zeros so that stale wen/dest bits
  // can never leak into the hazard compare.
  localparam dest_entry_t ENTRY_BUBBLE = '0;

  // Stage-index width; a single-stage tracker still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dest_pipe_tracker_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_dest_slot                                                  |
// | Purpose  : One pipeline stage register of the destination tracker.         |
// |            Hold has priority over flush, flush over load.                  |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            hold  - keep current contents                                   |
// |            flush - load the canonical bubble                               |
// |            d     - next entry presented by the tracker                     |
// |            q     - registered entry                                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipe_dest_slot
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  dest_entry_t d,
  output dest_entry_t q
);

  dest_entry_t r_q;

  // A flush arriving while the stage is held is dropped; the controller
  // is expected to reassert it once the hold clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= ENTRY_BUBBLE;
    end else if (hold) begin
      r_q <= r_q;
    end else if (flush) begin
      r_q <= ENTRY_BUBBLE;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/dest_pipe_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dest_pipe_tracker                                               |
// | Purpose  : Carries {valid, wen, dest} of in-flight instructions through    |
// |            DEPTH stage registers (stage 0 = EX/MEM) with per-stage hold    |
// |            and flush, and reports RAW hazards for two source operands.     |
// | Ports    : clk, rst_n            clock, async active-low reset             |
// |            in_valid/in_wen/in_dest  instruction leaving EX                 |
// |            bubble[DEPTH]         per-stage hold request                    |
// |            flush[DEPTH]          per-stage clear request                   |
// |            stage_valid/stage_wen/stage_dest  registered stage contents     |
// |            hold_eff[DEPTH]       effective hold (depends on bubble only)   |
// |            rs1/rs2               source operands under decode              |
// |            rsX_hit/rsX_stage     pending-write match, youngest stage       |
// | Note     : AW must equal pipe_pkg::AW (entry layout lives in the package). |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dest_pipe_tracker #(
  parameter int AW    = pipe_pkg::AW,
  parameter int DEPTH = pipe_pkg::DEPTH_DEFAULT,
  parameter int IDXW  = pipe_pkg::clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_wen,
  input  logic [AW-1:0]     in_dest,
  input  logic [DEPTH-1:0]  bubble,
  input  logic [DEPTH-1:0]  flush,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [DEPTH-1:0]  stage_wen,
  output logic [DEPTH*AW-1:0] stage_dest,
  output logic [DEPTH-1:0]  hold_eff,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic              rs1_hit,
  output logic              rs2_hit,
  output logic [IDXW-1:0]   rs1_stage,
  output logic [IDXW-1:0]   rs2_stage
);

  import pipe_pkg::*;

  logic [DEPTH-1:0] w_hold;
  dest_entry_t      w_in;
  dest_entry_t      w_src [DEPTH];
  dest_entry_t      w_q   [DEPTH];

  // A stalled stage freezes everything younger than it, so the hold
  // ripples from the oldest stage toward stage 0.
  always_comb begin
    w_hold[DEPTH-1] = bubble[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_hold[i] = bubble[i] | w_hold[i+1];
    end
  end

  assign hold_eff = w_hold;

  // Canonicalise the EX entry: a non-instruction never carries wen/dest.
  always_comb begin
    w_in = ENTRY_BUBBLE;
    if (in_valid) begin
      w_in.valid = 1'b1;
      w_in.wen   = in_wen;
      w_in.dest  = in_dest;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign w_src[i] = w_in;
      end else begin : g_body
        // When the younger stage is frozen its entry stays put, so this
        // stage takes a bubble rather than a duplicate.
        assign w_src[i] = w_hold[i-1] ? ENTRY_BUBBLE : w_q[i-1];
      end

      pipe_dest_slot u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (w_hold[i]),
        .flush (flush[i]),
        .d     (w_src[i]),
        .q     (w_q[i])
      );

      assign stage_valid[i]         = w_q[i].valid;
      assign stage_wen[i]           = w_q[i].wen;
      assign stage_dest[i*AW +: AW] = w_q[i].dest;
    end
  endgenerate

  // Hazard lookup from registered state only. Scanning oldest to youngest
  // lets the youngest match overwrite, giving lowest-index priority.
  // x0 is hard-wired zero and never a real dependency.
  always_comb begin
    rs1_hit   = 1'b0;
    rs1_stage = '0;
    rs2_hit   = 1'b0;
    rs2_stage = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_q[i].valid && w_q[i].wen && (w_q[i].dest == rs1) && (rs1 != '0)) begin
        rs1_hit   = 1'b1;
        rs1_stage = IDXW'(i);
      end
      if (w_q[i].valid && w_q[i].wen && (w_q[i].dest == rs2) && (rs2 != '0)) begin
        rs2_hit   = 1'b1;
        rs2_stage = IDXW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dest_pipe_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dest_pipe_tracker                                            |
// | Purpose  : Directed table-driven checks of a 3-stage tracker, reset        |
// |            corner cases, and a random bubble/flush sweep of 1- and 5-stage |
// |            trackers against a behavioural model.                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dest_pipe_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- 3-stage DUT ----------------
  logic       iv, iw;
  logic [4:0] id, r1, r2;
  logic [2:0] bub, fl;
  logic [2:0] sv, sw, he;
  logic [14:0] sd;
  logic       h1, h2;
  logic [1:0] st1, st2;

  dest_pipe_tracker #(.AW(5), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_wen(iw), .in_dest(id),
    .bubble(bub), .flush(fl), .stage_valid(sv), .stage_wen(sw),
    .stage_dest(sd), .hold_eff(he), .rs1(r1), .rs2(r2),
    .rs1_hit(h1), .rs2_hit(h2), .rs1_stage(st1), .rs2_stage(st2)
  );

  // ---------------- sweep DUTs (DEPTH 1 and 5) ----------------
  logic       w_iv, w_iw;
  logic [4:0] w_id, w_r1, w_r2;
  logic [0:0] b1, f1, a_v, a_w, a_he;
  logic [4:0] a_d;
  logic       a_h1, a_h2;
  logic [0:0] a_s1, a_s2;
  logic [4:0] b5, f5, c_v, c_w, c_he;
  logic [24:0] c_d;
  logic       c_h1, c_h2;
  logic [2:0] c_s1, c_s2;

  dest_pipe_tracker #(.AW(5), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_wen(w_iw), .in_dest(w_id),
    .bubble(b1), .flush(f1), .stage_valid(a_v), .stage_wen(a_w),
    .stage_dest(a_d), .hold_eff(a_he), .rs1(w_r1), .rs2(w_r2),
    .rs1_hit(a_h1), .rs2_hit(a_h2), .rs1_stage(a_s1), .rs2_stage(a_s2)
  );

  dest_pipe_tracker #(.AW(5), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_wen(w_iw), .in_dest(w_id),
    .bubble(b5), .flush(f5), .stage_valid(c_v), .stage_wen(c_w),
    .stage_dest(c_d), .hold_eff(c_he), .rs1(w_r1), .rs2(w_r2),
    .rs1_hit(c_h1), .rs2_hit(c_h2), .rs1_stage(c_s1), .rs2_stage(c_s2)
  );

  // ---------------- behavioural model for the sweep ----------------
  logic       m_v [2][5];
  logic       m_w [2][5];
  logic [4:0] m_d [2][5];

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 5; i++) begin
        m_v[k][i] = 1'b0; m_w[k][i] = 1'b0; m_d[k][i] = 5'd0;
      end
  endtask

  task automatic model_hold(input int d, input logic [4:0] b, output logic [4:0] hold);
    hold = '0;
    for (int i = d - 1; i >= 0; i--) begin
      if (i == d - 1) hold[i] = b[i];
      else            hold[i] = b[i] | hold[i+1];
    end
  endtask

  task automatic model_step(input int k, input int d, input logic [4:0] b,
                            input logic [4:0] f);
    logic       ov [5];
    logic       ow [5];
    logic [4:0] od [5];
    logic [4:0] hold;
    model_hold(d, b, hold);
    for (int i = 0; i < 5; i++) begin
      ov[i] = m_v[k][i]; ow[i] = m_w[k][i]; od[i] = m_d[k][i];
    end
    for (int i = 0; i < d; i++) begin
      if (hold[i]) begin
        // keep
      end else if (f[i]) begin
        m_v[k][i] = 1'b0; m_w[k][i] = 1'b0; m_d[k][i] = 5'd0;
      end else if (i == 0) begin
        m_v[k][i] = w_iv;
        m_w[k][i] = w_iv & w_iw;
        m_d[k][i] = w_iv ? w_id : 5'd0;
      end else if (hold[i-1]) begin
        m_v[k][i] = 1'b0; m_w[k][i] = 1'b0; m_d[k][i] = 5'd0;
      end else begin
        m_v[k][i] = ov[i-1]; m_w[k][i] = ow[i-1]; m_d[k][i] = od[i-1];
      end
    end
  endtask

  task automatic model_lookup(input int k, input int d, input logic [4:0] rs,
                              output logic hit, output logic [2:0] st);
    hit = 1'b0;
    st  = 3'd0;
    for (int i = 0; i < d; i++) begin
      if (!hit && m_v[k][i] && m_w[k][i] && (m_d[k][i] == rs) && (rs != 5'd0)) begin
        hit = 1'b1;
        st  = 3'(i);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] bub, fl;
    logic       iv, iw;
    logic [4:0] id, rs1, rs2;
    logic [2:0] ev, ew;
    logic [4:0] d0, d1, d2;
    logic [2:0] hold;
    logic       h1;
    logic [1:0] s1;
    logic       h2;
    logic [1:0] s2;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  initial begin
    logic [4:0] eh;
    logic [4:0] ev5, ew5;
    logic [24:0] ed5;
    logic       eh1, eh2;
    logic [2:0] es1, es2;

    // bub    fl    iv    iw    id     rs1    rs2  | ev     ew     d0     d1     d2     hold   h1    s1     h2    s2
    vt[0]  = '{3'b000,3'b000,1'b1,1'b1,5'd3, 5'd7, 5'd3, 3'b011,3'b011,5'd3, 5'd7, 5'd0, 3'b000,1'b1,2'd1,1'b1,2'd0};
    vt[1]  = '{3'b000,3'b000,1'b1,1'b1,5'd4, 5'd7, 5'd0, 3'b111,3'b111,5'd4, 5'd3, 5'd7, 3'b000,1'b1,2'd2,1'b0,2'd0};
    vt[2]  = '{3'b000,3'b000,1'b1,1'b1,5'd5, 5'd4, 5'd3, 3'b111,3'b111,5'd5, 5'd4, 5'd3, 3'b000,1'b1,2'd1,1'b1,2'd2};
    vt[3]  = '{3'b000,3'b000,1'b1,1'b1,5'd6, 5'd0, 5'd0, 3'b111,3'b111,5'd6, 5'd5, 5'd4, 3'b000,1'b0,2'd0,1'b0,2'd0};
    vt[4]  = '{3'b000,3'b000,1'b1,1'b1,5'd8, 5'd5, 5'd8, 3'b111,3'b111,5'd8, 5'd6, 5'd5, 3'b000,1'b1,2'd2,1'b1,2'd0};
    vt[5]  = '{3'b000,3'b000,1'b1,1'b1,5'd9, 5'd6, 5'd9, 3'b111,3'b111,5'd9, 5'd8, 5'd6, 3'b000,1'b1,2'd2,1'b1,2'd0};
    // back-stall on stage 1 for two cycles, then release
    vt[6]  = '{3'b010,3'b000,1'b1,1'b1,5'd10,5'd8, 5'd6, 3'b011,3'b011,5'd9, 5'd8, 5'd0, 3'b011,1'b1,2'd1,1'b0,2'd0};
    vt[7]  = '{3'b010,3'b000,1'b1,1'b1,5'd11,5'd9, 5'd10,3'b011,3'b011,5'd9, 5'd8, 5'd0, 3'b011,1'b1,2'd0,1'b0,2'd0};
    vt[8]  = '{3'b000,3'b000,1'b1,1'b1,5'd11,5'd8, 5'd11,3'b111,3'b111,5'd11,5'd9, 5'd8, 3'b000,1'b1,2'd2,1'b1,2'd0};
    // flush without hold, then flush with stage 0 held
    vt[9]  = '{3'b000,3'b011,1'b1,1'b1,5'd12,5'd9, 5'd12,3'b100,3'b100,5'd0, 5'd0, 5'd9, 3'b000,1'b1,2'd2,1'b0,2'd0};
    vt[10] = '{3'b000,3'b000,1'b1,1'b1,5'd13,5'd13,5'd9, 3'b001,3'b001,5'd13,5'd0, 5'd0, 3'b000,1'b1,2'd0,1'b0,2'd0};
    vt[11] = '{3'b001,3'b011,1'b1,1'b1,5'd14,5'd13,5'd14,3'b001,3'b001,5'd13,5'd0, 5'd0, 3'b001,1'b1,2'd0,1'b0,2'd0};
    // priority, wen=0 and x0
    vt[12] = '{3'b000,3'b000,1'b1,1'b1,5'd12,5'd12,5'd13,3'b011,3'b011,5'd12,5'd13,5'd0, 3'b000,1'b1,2'd0,1'b1,2'd1};
    vt[13] = '{3'b000,3'b000,1'b1,1'b0,5'd12,5'd13,5'd12,3'b111,3'b110,5'd12,5'd12,5'd13,3'b000,1'b1,2'd2,1'b1,2'd1};
    vt[14] = '{3'b000,3'b000,1'b1,1'b1,5'd12,5'd12,5'd13,3'b111,3'b101,5'd12,5'd12,5'd12,3'b000,1'b1,2'd0,1'b0,2'd0};
    vt[15] = '{3'b000,3'b000,1'b1,1'b1,5'd0, 5'd12,5'd0, 3'b111,3'b011,5'd0, 5'd12,5'd12,3'b000,1'b1,2'd1,1'b0,2'd0};
    vt[16] = '{3'b000,3'b000,1'b1,1'b0,5'd12,5'd12,5'd0, 3'b111,3'b110,5'd12,5'd0, 5'd12,3'b000,1'b1,2'd2,1'b0,2'd0};
    vt[17] = '{3'b000,3'b000,1'b0,1'b1,5'd7, 5'd12,5'd0, 3'b110,3'b100,5'd0, 5'd12,5'd0, 3'b000,1'b0,2'd0,1'b0,2'd0};

    // ---------- reset with EX busy ----------
    rst_n = 1'b0;
    iv = 1'b1; iw = 1'b1; id = 5'd7; r1 = 5'd7; r2 = 5'd0;
    bub = '0; fl = '0;
    w_iv = 1'b0; w_iw = 1'b0; w_id = '0; w_r1 = '0; w_r2 = '0;
    b1 = '0; f1 = '0; b5 = '0; f5 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", sv, 3'b000);
    chk("rst_wen", sw, 3'b000);
    chk("rst_dest", sd, 15'd0);
    chk("rst_rs1_hit", h1, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", sv, 3'b001);
    chk("rel_wen", sw, 3'b001);
    chk("rel_dest0", sd[4:0], 5'd7);
    chk("rel_rs1_hit", h1, 1'b1);
    chk("rel_rs1_stage", st1, 2'd0);

    // ---------- table ----------
    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      bub = vt[n].bub; fl = vt[n].fl;
      iv = vt[n].iv; iw = vt[n].iw; id = vt[n].id;
      r1 = vt[n].rs1; r2 = vt[n].rs2;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", n), sv, vt[n].ev);
      chk($sformatf("v%0d_wen", n), sw, vt[n].ew);
      chk($sformatf("v%0d_dest0", n), sd[4:0], vt[n].d0);
      chk($sformatf("v%0d_dest1", n), sd[9:5], vt[n].d1);
      chk($sformatf("v%0d_dest2", n), sd[14:10], vt[n].d2);
      chk($sformatf("v%0d_hold", n), he, vt[n].hold);
      chk($sformatf("v%0d_rs1_hit", n), h1, vt[n].h1);
      chk($sformatf("v%0d_rs1_stage", n), st1, vt[n].s1);
      chk($sformatf("v%0d_rs2_hit", n), h2, vt[n].h2);
      chk($sformatf("v%0d_rs2_stage", n), st2, vt[n].s2);
    end

    // hold_eff is purely combinational on bubble
    @(negedge clk);
    bub = 3'b100; #1;
    chk("comb_hold_100", he, 3'b111);
    bub = 3'b001; #1;
    chk("comb_hold_001", he, 3'b001);

    // ---------- reset mid-stall/mid-flush, between clock edges ----------
    bub = 3'b010; fl = 3'b111; iv = 1'b1; iw = 1'b1; id = 5'd5;
    r1 = 5'd12; r2 = 5'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", sv, 3'b000);
    chk("async_rst_dest", sd, 15'd0);
    chk("async_rst_rs1_hit", h1, 1'b0);
    @(posedge clk); #1;
    chk("held_rst_valid", sv, 3'b000);

    // ---------- random sweep: DEPTH=1 and DEPTH=5 vs model ----------
    bub = '0; fl = '0; iv = 1'b0;
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      w_iv = ($urandom_range(3) != 0);
      w_iw = ($urandom_range(3) != 0);
      w_id = 5'($urandom_range(7));
      w_r1 = 5'($urandom_range(7));
      w_r2 = 5'($urandom_range(7));
      b1[0] = ($urandom_range(3) == 0);
      f1[0] = ($urandom_range(4) == 0);
      for (int i = 0; i < 5; i++) begin
        b5[i] = ($urandom_range(5) == 0);
        f5[i] = ($urandom_range(5) == 0);
      end
      @(posedge clk);
      model_step(0, 1, {4'b0, b1}, {4'b0, f1});
      model_step(1, 5, b5, f5);
      #1;
      // DEPTH=1
      model_hold(1, {4'b0, b1}, eh);
      chk("d1_hold", a_he, eh[0]);
      chk("d1_valid", a_v, m_v[0][0]);
      chk("d1_wen", a_w, m_w[0][0]);
      chk("d1_dest", a_d, m_d[0][0]);
      model_lookup(0, 1, w_r1, eh1, es1);
      model_lookup(0, 1, w_r2, eh2, es2);
      chk("d1_rs1_hit", a_h1, eh1);
      chk("d1_rs1_stage", a_s1, es1[0]);
      chk("d1_rs2_hit", a_h2, eh2);
      chk("d1_rs2_stage", a_s2, es2[0]);
      // DEPTH=5
      model_hold(5, b5, eh);
      for (int i = 0; i < 5; i++) begin
        ev5[i] = m_v[1][i];
        ew5[i] = m_w[1][i];
        ed5[i*5 +: 5] = m_d[1][i];
      end
      chk("d5_hold", c_he, eh);
      chk("d5_valid", c_v, ev5);
      chk("d5_wen", c_w, ew5);
      chk("d5_dest", c_d, ed5);
      model_lookup(1, 5, w_r1, eh1, es1);
      model_lookup(1, 5, w_r2, eh2, es2);
      chk("d5_rs1_hit", c_h1, eh1);
      chk("d5_rs1_stage", c_s1, es1);
      chk("d5_rs2_hit", c_h2, eh2);
      chk("d5_rs2_stage", c_s2, es2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
